// File: rtl/deskew_axi_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// deskew_axi_pkg : register indices, response codes and FSM states
// Rev 1.0
// ----------------------------------------------------------------------------
package deskew_axi_pkg;

    localparam logic [1:0] CMD_IDX      = 2'd0;
    localparam logic [1:0] STATUS_IDX   = 2'd1;
    localparam logic [1:0] IRQ_EN_IDX   = 2'd2;
    localparam logic [1:0] IRQ_STAT_IDX = 2'd3;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ACK  = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ACK  = 2'd1,
        R_RESP = 2'd2
    } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/deskew_irq_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// deskew_irq_ctrl : ready rising-edge detect, sticky W1C done flag, irq output
// Rev 1.0
// ----------------------------------------------------------------------------
module deskew_irq_ctrl (
    input  logic clk,
    input  logic reset,
    input  logic i_status,
    input  logic i_w1c,
    input  logic i_irq_en_next,
    output logic o_done_flag,
    output logic o_irq
);

    logic r_status_q;
    logic r_done_flag;
    logic r_irq;
    logic w_rise;
    logic w_done_next;

    assign w_rise = i_status & ~r_status_q;

    // A new rising edge beats a simultaneous software clear.
    assign w_done_next = w_rise ? 1'b1 : (i_w1c ? 1'b0 : r_done_flag);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_status_q  <= 1'b0;
            r_done_flag <= 1'b0;
            r_irq       <= 1'b0;
        end else begin
            r_status_q  <= i_status;
            r_done_flag <= w_done_next;
            r_irq       <= w_done_next & i_irq_en_next;
        end
    end

    assign o_done_flag = r_done_flag;
    assign o_irq       = r_irq;

endmodule
`default_nettype wire

// File: rtl/deskew_axi_lite_regs.sv
`default_nettype none
// ----------------------------------------------------------------------------
// deskew_axi_lite_regs : AXI4-Lite slave for deskew command, status and irq
// Rev 1.0
// ----------------------------------------------------------------------------
module deskew_axi_lite_regs
    import deskew_axi_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    output logic [1:0]                      s_axi_bresp,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                      s_axi_rresp,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    output logic                            cmd_wr_o,
    input  logic                            cmd_rb_i,
    input  logic                            status_axi_i,
    output logic                            irq_o
);

    wr_state_t r_wr_state, w_wr_next;
    rd_state_t r_rd_state, w_rd_next;

    logic [1:0]                    r_wr_idx;
    logic                          r_wr_bit;
    logic                          r_wr_strb0;
    logic [1:0]                    r_rd_idx;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;
    logic                          r_cmd;
    logic                          r_irq_en;
    logic                          w_wr_commit;
    logic                          w_irq_en_next;
    logic                          w_w1c;
    logic                          w_rd_bit;
    logic                          w_done_flag;

    // ---------------- write channel ----------------
    always_ff @(posedge clk) begin
        if (reset) r_wr_state <= W_IDLE;
        else       r_wr_state <= w_wr_next;
    end

    always_comb begin
        w_wr_next = r_wr_state;
        case (r_wr_state)
            W_IDLE:  if (s_axi_awvalid && s_axi_wvalid) w_wr_next = W_ACK;
            W_ACK:   w_wr_next = W_RESP;
            W_RESP:  if (s_axi_bready) w_wr_next = W_IDLE;
            default: w_wr_next = W_IDLE;
        endcase
    end

    // Address and data are taken together so a lone valid never half-captures.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_idx   <= 2'd0;
            r_wr_bit   <= 1'b0;
            r_wr_strb0 <= 1'b0;
        end else if (r_wr_state == W_IDLE && s_axi_awvalid && s_axi_wvalid) begin
            r_wr_idx   <= s_axi_awaddr[3:2];
            r_wr_bit   <= s_axi_wdata[0];
            r_wr_strb0 <= s_axi_wstrb[0];
        end
    end

    assign w_wr_commit   = (r_wr_state == W_ACK) && r_wr_strb0;
    assign w_irq_en_next = (w_wr_commit && r_wr_idx == IRQ_EN_IDX) ? r_wr_bit : r_irq_en;
    assign w_w1c         = w_wr_commit && (r_wr_idx == IRQ_STAT_IDX) && r_wr_bit;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cmd    <= 1'b0;
            r_irq_en <= 1'b0;
        end else begin
            if (w_wr_commit && r_wr_idx == CMD_IDX) r_cmd <= r_wr_bit;
            r_irq_en <= w_irq_en_next;
        end
    end

    assign s_axi_awready = (r_wr_state == W_ACK);
    assign s_axi_wready  = (r_wr_state == W_ACK);
    assign s_axi_bvalid  = (r_wr_state == W_RESP);
    assign s_axi_bresp   = AXI_RESP_OKAY;

    // ---------------- read channel ----------------
    always_ff @(posedge clk) begin
        if (reset) r_rd_state <= R_IDLE;
        else       r_rd_state <= w_rd_next;
    end

    always_comb begin
        w_rd_next = r_rd_state;
        case (r_rd_state)
            R_IDLE:  if (s_axi_arvalid) w_rd_next = R_ACK;
            R_ACK:   w_rd_next = R_RESP;
            R_RESP:  if (s_axi_rready) w_rd_next = R_IDLE;
            default: w_rd_next = R_IDLE;
        endcase
    end

    always_comb begin
        w_rd_bit = 1'b0;
        case (r_rd_idx)
            CMD_IDX:      w_rd_bit = cmd_rb_i;
            STATUS_IDX:   w_rd_bit = status_axi_i;
            IRQ_EN_IDX:   w_rd_bit = r_irq_en;
            IRQ_STAT_IDX: w_rd_bit = w_done_flag;
            default:      w_rd_bit = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_idx <= 2'd0;
            r_rdata  <= '0;
        end else begin
            if (r_rd_state == R_IDLE && s_axi_arvalid) r_rd_idx <= s_axi_araddr[3:2];
            if (r_rd_state == R_ACK) r_rdata <= {{(C_S_AXI_DATA_WIDTH-1){1'b0}}, w_rd_bit};
        end
    end

    assign s_axi_arready = (r_rd_state == R_ACK);
    assign s_axi_rvalid  = (r_rd_state == R_RESP);
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rresp   = AXI_RESP_OKAY;

    // ---------------- interrupt ----------------
    deskew_irq_ctrl u_irq_ctrl (
        .clk           (clk),
        .reset         (reset),
        .i_status      (status_axi_i),
        .i_w1c         (w_w1c),
        .i_irq_en_next (w_irq_en_next),
        .o_done_flag   (w_done_flag),
        .o_irq         (irq_o)
    );

    assign cmd_wr_o = r_cmd;

    // Only bit 0 and the word index are decoded.
    logic w_unused;
    assign w_unused = &{1'b0, s_axi_awaddr, s_axi_araddr, s_axi_wdata, s_axi_wstrb};

endmodule
`default_nettype wire

// File: tb/tb_deskew_axi_lite_regs.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_deskew_axi_lite_regs : scoreboard bench for the deskew AXI-Lite registers
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_deskew_axi_lite_regs;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  s_axi_awaddr;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [3:0]  s_axi_araddr;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready;
    logic        cmd_wr_o;
    logic        cmd_rb_i;
    logic        status_axi_i;
    logic        irq_o;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    deskew_axi_lite_regs #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .cmd_wr_o      (cmd_wr_o),
        .cmd_rb_i      (cmd_rb_i),
        .status_axi_i  (status_axi_i),
        .irq_o         (irq_o)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one write; aw_lead cycles of awvalid alone, b_delay cycles of bready low.
    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int aw_lead, input int b_delay);
        s_axi_awaddr  = addr;
        s_axi_awvalid = 1'b1;
        for (int i = 0; i < aw_lead; i++) begin
            tick();
            check_val("awready_wait", s_axi_awready, 0);
        end
        s_axi_wdata  = data;
        s_axi_wstrb  = strb;
        s_axi_wvalid = 1'b1;
        tick();
        check_val("awready_n1", s_axi_awready, 1);
        check_val("wready_n1", s_axi_wready, 1);
        tick();
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        check_val("awready_n2", s_axi_awready, 0);
        check_val("bvalid_n2", s_axi_bvalid, 1);
        check_val("bresp", s_axi_bresp, 0);
        for (int i = 0; i < b_delay; i++) begin
            tick();
            check_val("bvalid_hold", s_axi_bvalid, 1);
        end
        s_axi_bready = 1'b1;
        tick();
        s_axi_bready = 1'b0;
        check_val("bvalid_done", s_axi_bvalid, 0);
    endtask

    task automatic axi_read(input logic [3:0] addr, input logic [31:0] exp);
        int wait_cnt;
        logic [31:0] want;
        s_axi_araddr  = addr;
        s_axi_arvalid = 1'b1;
        exp_q.push_back(exp);
        tick();
        check_val("arready", s_axi_arready, 1);
        tick();
        s_axi_arvalid = 1'b0;
        wait_cnt = 0;
        while (!s_axi_rvalid && wait_cnt < 20) begin
            tick();
            wait_cnt++;
        end
        want = exp_q.pop_front();
        if (!s_axi_rvalid) begin
            check_val("rvalid_timeout", {31'd0, s_axi_rvalid}, 1);
        end else begin
            check_val("rdata", s_axi_rdata, want);
            check_val("rresp", s_axi_rresp, 0);
            s_axi_rready = 1'b1;
            tick();
            s_axi_rready = 1'b0;
            check_val("rvalid_done", s_axi_rvalid, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        s_axi_awaddr = '0; s_axi_awvalid = 0; s_axi_wdata = '0; s_axi_wstrb = '0;
        s_axi_wvalid = 0; s_axi_bready = 0; s_axi_araddr = '0; s_axi_arvalid = 0;
        s_axi_rready = 0; cmd_rb_i = 0; status_axi_i = 0;
        repeat (3) tick();
        check_val("rst_awready", s_axi_awready, 0);
        check_val("rst_bvalid", s_axi_bvalid, 0);
        check_val("rst_arready", s_axi_arready, 0);
        check_val("rst_rvalid", s_axi_rvalid, 0);
        check_val("rst_cmd", cmd_wr_o, 0);
        check_val("rst_irq", irq_o, 0);
        reset = 1'b0;
        tick();

        // Basic command write and readback
        axi_write(4'h0, 32'h1, 4'hF, 0, 0);
        check_val("cmd_set", cmd_wr_o, 1);
        cmd_rb_i = 1'b1;
        axi_read(4'h0, 32'h1);

        // Late wvalid, slow bready, masked strobe
        axi_write(4'h0, 32'h0, 4'h0, 3, 4);
        check_val("cmd_strb0", cmd_wr_o, 1);
        axi_write(4'h0, 32'h0, 4'h1, 0, 0);
        check_val("cmd_clr", cmd_wr_o, 0);
        cmd_rb_i = 1'b0;
        axi_read(4'h0, 32'h0);

        // Interrupt on ready rising edge, then W1C
        axi_write(4'h8, 32'h1, 4'h1, 0, 0);
        axi_read(4'h8, 32'h1);
        check_val("irq_pre", irq_o, 0);
        status_axi_i = 1'b1;
        check_val("irq_same_cycle", irq_o, 0);
        tick();
        check_val("irq_rise", irq_o, 1);
        axi_read(4'hC, 32'h1);
        axi_read(4'h4, 32'h1);
        axi_write(4'hC, 32'h1, 4'h1, 0, 0);
        check_val("irq_w1c", irq_o, 0);
        axi_read(4'hC, 32'h0);
        repeat (3) tick();
        check_val("irq_no_reset", irq_o, 0);

        // W1C landing in the same cycle as a rising edge
        status_axi_i = 1'b0;
        repeat (2) tick();
        fork
            axi_write(4'hC, 32'h1, 4'h1, 0, 0);
            begin
                tick();
                status_axi_i = 1'b1;
            end
        join
        check_val("irq_set_wins", irq_o, 1);
        axi_read(4'hC, 32'h1);

        // Overlapping read and write, write to read-only register
        fork
            axi_read(4'h4, 32'h1);
            axi_write(4'h8, 32'h0, 4'h1, 0, 0);
        join
        check_val("irq_en_off", irq_o, 0);
        axi_read(4'h8, 32'h0);
        axi_write(4'h4, 32'h0, 4'hF, 0, 0);
        axi_read(4'h4, 32'h1);
        axi_read(4'hC, 32'h1);

        // Reset in W_RESP
        status_axi_i = 1'b0;
        s_axi_awaddr = 4'h0; s_axi_wdata = 32'h1; s_axi_wstrb = 4'h1;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        tick();
        tick();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        check_val("abort_bvalid_pre", s_axi_bvalid, 1);
        check_val("abort_cmd_pre", cmd_wr_o, 1);
        reset = 1'b1;
        tick();
        check_val("abort_bvalid", s_axi_bvalid, 0);
        check_val("abort_cmd", cmd_wr_o, 0);
        reset = 1'b0;
        tick();

        // Reset in R_ACK
        s_axi_araddr = 4'h0; s_axi_arvalid = 1'b1;
        tick();
        check_val("abort_arready_pre", s_axi_arready, 1);
        reset = 1'b1;
        s_axi_arvalid = 1'b0;
        tick();
        check_val("abort_arready", s_axi_arready, 0);
        check_val("abort_rvalid", s_axi_rvalid, 0);
        reset = 1'b0;
        tick();

        // Normal traffic after aborted transactions
        axi_read(4'h8, 32'h0);
        axi_read(4'hC, 32'h0);
        axi_write(4'h0, 32'h1, 4'hF, 0, 0);
        check_val("post_cmd", cmd_wr_o, 1);
        cmd_rb_i = 1'b1;
        axi_read(4'h0, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
